param_register_file: RTL and testbench
======================================

Name: param_register_file

Overview:
- Parametrised successor to the stage-2 register file: configurable data width and register count, two write ports, and a dedicated auxiliary register (AUX_REG) reachable from read port 2 and write port 2.
- Adds a per-register pending scoreboard for decode-stage hazard detection and a one-register-per-cycle clear sequencer.
- Sits in the decode stage: reads feed the ID/EX latch, writes come from writeback.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; NUM_REGS = 2**ADDR_W.
- AUX_REG, 15, index of the auxiliary register; must be < NUM_REGS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_aux_sel  in  1  1: port 2 reads AUX_REG and ignores rd_addr2.
- rd_data1  out  DATA_W  combinational read data, port 1.
- rd_data2  out  DATA_W  combinational read data, port 2.
- pend1  out  1  pending bit of the port 1 register.
- pend2  out  1  pending bit of the effective port 2 register.
- wr_mode  in  2  00 none, 01 port 1 only, 10 both ports, 11 none (reserved).
- wr_addr1  in  ADDR_W  write port 1 address.
- wr_data1  in  DATA_W  write port 1 data.
- wr_addr2  in  ADDR_W  write port 2 address.
- wr_data2  in  DATA_W  write port 2 data.
- wr2_aux  in  1  1: port 2 writes AUX_REG and ignores wr_addr2.
- issue_valid  in  1  marks issue_addr pending.
- issue_addr  in  ADDR_W  destination of the issuing instruction.
- clr_req  in  1  starts the clear sweep.
- clr_busy  out  1  high while the sweep runs.

Behaviour:
- Reset (rst=1, async): all registers 0, all pending bits 0, FSM IDLE, clr_busy 0. Reset asserted mid-sweep aborts the sweep; the block leaves reset in IDLE.
- Reads are combinational. The effective port 2 address is AUX_REG when rd_aux_sel=1, else rd_addr2.
- Writes take effect at the clock edge after wr_mode is presented (1-cycle write latency).
  - wr_mode=01: port 1 writes.
  - wr_mode=10: both ports write.
  - Both ports target the same register: port 2 data wins.
- Scoreboard, one bit per register, updated at the clock edge:
  - Set: issue_valid=1 sets pending[issue_addr].
  - Clear: a write on port 1 or port 2 clears the bit of the register it writes.
  - Set and clear on the same register in the same cycle: set wins.
- Clear FSM:
  - IDLE: clr_req=1 moves to SWEEP with ptr=0.
  - SWEEP: each cycle writes 0 to reg[ptr] and clears pending[ptr], then increments ptr. At ptr=NUM_REGS-1 returns to IDLE after that write.
  - clr_busy=1 exactly while in SWEEP (NUM_REGS cycles).
  - During SWEEP: wr_mode and issue_valid are ignored and clr_req is ignored. Reads stay live and return stored values.
- ptr width is ADDR_W; the terminal value is handled without wrap, so there is no overflow.

Optional Feature:
- Macro: PRF_WRITE_BYPASS_EN.
- Defined:
  - Any read whose effective address matches an accepted same-cycle write returns that write data (port 2 over port 1).
  - pend1/pend2 read 0 for a register being written that cycle, unless issue_valid targets it in the same cycle.
  - Sweep writes are never bypassed.
- Undefined:
  - Reads return the pre-edge stored value.
  - pend1/pend2 reflect the registered bits only.

Test Plan:
1. Reset, then read all addresses -> every rd_data is 0, pend1/pend2 are 0, clr_busy=0.
2. wr_mode=10, wr_addr1=3/0x1234, wr_addr2=3/0xABCD -> next cycle, reading reg 3 gives 0xABCD. Then wr2_aux=1, wr_data2=0x5555 with rd_aux_sel=1 -> rd_data2=0x5555 next cycle.
3. issue_valid to reg 5 -> pend1=1 for rd_addr1=5. wr_mode=01 to reg 5 with issue_valid to reg 5 in the same cycle -> pend stays 1. Next write to reg 5 without issue -> pend1=0.
4. With PRF_WRITE_BYPASS_EN, wr_mode=01, reg 7 = 0x00FF, rd_addr1=7 in the same cycle -> rd_data1=0x00FF combinationally. Without the macro -> old value.
5. Load regs 0-15, then pulse clr_req -> clr_busy high for 16 cycles. A wr_mode=01 write during the sweep is dropped. Afterwards all registers and pending bits are 0.
6. Assert rst at sweep cycle 6 -> immediate IDLE, clr_busy=0, all registers 0.

Source files
------------

// File: rtl/param_register_file.sv
// Decode-stage register file: two write ports, AUX_REG shortcut, per-register pending scoreboard and clear sweep.
// Define PRF_WRITE_BYPASS_EN to forward same-cycle write data and pending clears to the read ports.
module param_register_file #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int AUX_REG = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              rd_aux_sel,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              pend1,
  output logic              pend2,
  input  logic [1:0]        wr_mode,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [ADDR_W-1:0] wr_addr2,
  input  logic [DATA_W-1:0] wr_data2,
  input  logic              wr2_aux,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] AUX_ADDR = ADDR_W'(AUX_REG);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t              state;
  logic [DATA_W-1:0]   regFile [NUM_REGS];
  logic [NUM_REGS-1:0] pendBits;
  logic [NUM_REGS-1:0] pendNext;
  logic [NUM_REGS-1:0] wrHit;
  logic [ADDR_W-1:0]   sweepPtr;
  logic [ADDR_W-1:0]   rdAddr2Eff;
  logic [ADDR_W-1:0]   wrAddr2Eff;
  logic                accept;
  logic                wrEn1;
  logic                wrEn2;
  logic                issueEn;

  // Port decode; the sweep owns the array, so normal traffic is gated off while it runs.
  always_comb begin
    accept     = (state == IDLE);
    wrEn1      = accept && ((wr_mode == 2'b01) || (wr_mode == 2'b10));
    wrEn2      = accept && (wr_mode == 2'b10);
    issueEn    = accept && issue_valid;
    wrAddr2Eff = wr2_aux ? AUX_ADDR : wr_addr2;
    rdAddr2Eff = rd_aux_sel ? AUX_ADDR : rd_addr2;
  end

  // Scoreboard next state: a write clears its register, an issue sets it, and the issue wins a tie.
  always_comb begin
    wrHit    = '0;
    pendNext = pendBits;
    for (int i = 0; i < NUM_REGS; i++) begin
      wrHit[i]    = (wrEn1 && (wr_addr1 == ADDR_W'(i))) || (wrEn2 && (wrAddr2Eff == ADDR_W'(i)));
      pendNext[i] = (issueEn && (issue_addr == ADDR_W'(i))) ? 1'b1 :
                    (wrHit[i] ? 1'b0 : pendBits[i]);
    end
  end

  // Storage, scoreboard and the clear sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sweepPtr <= '0;
      clr_busy <= 1'b0;
      pendBits <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile[i] <= '0;
      end
    end else if (state == SWEEP) begin
      regFile[sweepPtr]  <= '0;
      pendBits[sweepPtr] <= 1'b0;
      // Stop on the last index instead of letting the pointer wrap.
      if (sweepPtr == LAST_PTR) begin
        state    <= IDLE;
        clr_busy <= 1'b0;
      end else begin
        sweepPtr <= sweepPtr + 1'b1;
      end
    end else begin
      pendBits <= pendNext;
      if (wrEn1) begin
        regFile[wr_addr1] <= wr_data1;
      end
      // Port 2 is applied last so it overrides port 1 on an address collision.
      if (wrEn2) begin
        regFile[wrAddr2Eff] <= wr_data2;
      end
      if (clr_req) begin
        state    <= SWEEP;
        sweepPtr <= '0;
        clr_busy <= 1'b1;
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    rd_data1 = regFile[rd_addr1];
    rd_data2 = regFile[rdAddr2Eff];
    pend1    = pendBits[rd_addr1];
    pend2    = pendBits[rdAddr2Eff];
`ifdef PRF_WRITE_BYPASS_EN
    if (wrEn2 && (wrAddr2Eff == rd_addr1)) begin
      rd_data1 = wr_data2;
    end else if (wrEn1 && (wr_addr1 == rd_addr1)) begin
      rd_data1 = wr_data1;
    end else begin
      rd_data1 = regFile[rd_addr1];
    end
    if (wrEn2 && (wrAddr2Eff == rdAddr2Eff)) begin
      rd_data2 = wr_data2;
    end else if (wrEn1 && (wr_addr1 == rdAddr2Eff)) begin
      rd_data2 = wr_data1;
    end else begin
      rd_data2 = regFile[rdAddr2Eff];
    end
    if (wrHit[rd_addr1] && !(issueEn && (issue_addr == rd_addr1))) begin
      pend1 = 1'b0;
    end else begin
      pend1 = pendBits[rd_addr1];
    end
    if (wrHit[rdAddr2Eff] && !(issueEn && (issue_addr == rdAddr2Eff))) begin
      pend2 = 1'b0;
    end else begin
      pend2 = pendBits[rdAddr2Eff];
    end
`endif
  end

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file: directed stimulus queues expectations, a negedge monitor checks them.
module tb_param_register_file;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic        rd_aux_sel;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        pend1;
  logic        pend2;
  logic [1:0]  wr_mode;
  logic [3:0]  wr_addr1;
  logic [15:0] wr_data1;
  logic [3:0]  wr_addr2;
  logic [15:0] wr_data2;
  logic        wr2_aux;
  logic        issue_valid;
  logic [3:0]  issue_addr;
  logic        clr_req;
  logic        clr_busy;

  // mask bits: 0 rd_data1, 1 rd_data2, 2 pend1, 3 pend2, 4 clr_busy
  typedef struct {
    string       name;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        p1;
    logic        p2;
    logic        busy;
    logic [4:0]  mask;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  param_register_file #(.DATA_W(16), .ADDR_W(4), .AUX_REG(15)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_aux_sel(rd_aux_sel),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .pend1(pend1), .pend2(pend2),
    .wr_mode(wr_mode), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .wr_addr2(wr_addr2), .wr_data2(wr_data2), .wr2_aux(wr2_aux),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the oldest expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      cur = expQ.pop_front();
      checks++;
      if ((cur.mask[0] && (rd_data1 !== cur.d1)) || (cur.mask[1] && (rd_data2 !== cur.d2)) ||
          (cur.mask[2] && (pend1 !== cur.p1)) || (cur.mask[3] && (pend2 !== cur.p2)) ||
          (cur.mask[4] && (clr_busy !== cur.busy))) begin
        errors++;
        $display("FAIL %s: got d1=%h d2=%h p1=%b p2=%b busy=%b, want d1=%h d2=%h p1=%b p2=%b busy=%b (mask %b)",
                 cur.name, rd_data1, rd_data2, pend1, pend2, clr_busy,
                 cur.d1, cur.d2, cur.p1, cur.p2, cur.busy, cur.mask);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIns();
    wr_mode     = 2'b00;
    wr2_aux     = 1'b0;
    issue_valid = 1'b0;
    clr_req     = 1'b0;
    rd_aux_sel  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] m, input logic [3:0] a1, input logic [15:0] d1,
                    input logic [3:0] a2, input logic [15:0] d2, input logic aux);
    wr_mode  = m;
    wr_addr1 = a1;
    wr_data1 = d1;
    wr_addr2 = a2;
    wr_data2 = d2;
    wr2_aux  = aux;
  endtask

  task automatic issue(input logic [3:0] a);
    issue_valid = 1'b1;
    issue_addr  = a;
  endtask

  task automatic pushExp(input string n, input logic [15:0] d1, input logic [15:0] d2,
                         input logic p1, input logic p2, input logic busy, input logic [4:0] m);
    exp_t e;
    e.name = n; e.d1 = d1; e.d2 = d2; e.p1 = p1; e.p2 = p2; e.busy = busy; e.mask = m;
    expQ.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    idleIns();
    rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    wr_addr1 = 4'd0; wr_data1 = 16'h0000; wr_addr2 = 4'd0; wr_data2 = 16'h0000;
    issue_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state across all addresses.
    for (int i = 0; i < 8; i++) begin
      rd_addr1 = 4'(i);
      rd_addr2 = 4'(i + 8);
      pushExp("reset_read", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b11111);
      step();
    end

    // Dual write collision, AUX write, mode 01 ignores port 2, mode 11 writes nothing.
    wr(2'b10, 4'd3, 16'h1234, 4'd3, 16'hABCD, 1'b0);
    step();
    idleIns();
    rd_addr1 = 4'd3;
    pushExp("port2_wins", 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b10001);
    wr(2'b10, 4'd2, 16'h2222, 4'd0, 16'h5555, 1'b1);
    step();
    idleIns();
    rd_aux_sel = 1'b1;
    rd_addr1   = 4'd2;
    rd_addr2   = 4'd0;
    pushExp("aux_write", 16'h2222, 16'h5555, 1'b0, 1'b0, 1'b0, 5'b00011);
    wr(2'b01, 4'd6, 16'h6666, 4'd8, 16'h8888, 1'b0);
    step();
    wr(2'b11, 4'd4, 16'h4444, 4'd4, 16'h4444, 1'b0);
    step();
    idleIns();
    rd_addr1 = 4'd6;
    rd_addr2 = 4'd8;
    pushExp("mode01_only_port1", 16'h6666, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b00011);
    step();
    rd_addr1 = 4'd4;
    pushExp("mode11_no_write", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b00001);
    step();

    // Scoreboard set / clear / set-wins.
    issue(4'd5);
    step();
    idleIns();
    rd_addr1 = 4'd5;
    pushExp("issue_sets", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 5'b00100);
    wr(2'b01, 4'd5, 16'h0505, 4'd0, 16'h0000, 1'b0);
    issue(4'd5);
    step();
    idleIns();
    pushExp("set_wins", 16'h0505, 16'h0000, 1'b1, 1'b0, 1'b0, 5'b00101);
    wr(2'b01, 4'd5, 16'h0506, 4'd0, 16'h0000, 1'b0);
    step();
    idleIns();
    pushExp("write_clears", 16'h0506, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b00101);
    issue(4'd9);
    step();
    issue(4'd15);
    wr(2'b10, 4'd1, 16'h0101, 4'd9, 16'h0909, 1'b0);
    step();
    idleIns();
    rd_addr1   = 4'd9;
    rd_aux_sel = 1'b1;
    pushExp("port2_clear_aux_pend", 16'h0909, 16'h5555, 1'b0, 1'b1, 1'b0, 5'b01101);
    step();

    // Same-cycle read of a register being written.
    idleIns();
    issue(4'd7);
    step();
    idleIns();
    wr(2'b01, 4'd7, 16'h00FF, 4'd0, 16'h0000, 1'b0);
    rd_addr1 = 4'd7;
`ifdef PRF_WRITE_BYPASS_EN
    pushExp("bypass_read", 16'h00FF, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b00101);
`else
    pushExp("no_bypass_read", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 5'b00101);
`endif
    step();
    idleIns();
    pushExp("after_write_7", 16'h00FF, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b00101);
    step();

    // Load every register, mark 2 and 12 pending, then sweep.
    for (int i = 0; i < 8; i++) begin
      wr(2'b10, 4'(i), 16'hA000 + 16'(i), 4'(i + 8), 16'hA000 + 16'(i + 8), 1'b0);
      step();
    end
    idleIns();
    issue(4'd2);
    step();
    issue(4'd12);
    step();
    idleIns();
    rd_addr1 = 4'd12;
    rd_addr2 = 4'd2;
    pushExp("loaded", 16'hA00C, 16'hA002, 1'b1, 1'b1, 1'b0, 5'b11111);
    clr_req = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      idleIns();
      if (k == 3) begin
        wr(2'b01, 4'd0, 16'hDEAD, 4'd0, 16'h0000, 1'b0);
        issue(4'd0);
      end
      if (k == 5) begin
        clr_req = 1'b1;
      end
      rd_addr1 = 4'(k);
      rd_addr2 = 4'(k - 1);
      pushExp("sweep_cycle", 16'hA000 + 16'(k), 16'h0000, (k == 2) || (k == 12), 1'b0, 1'b1,
              (k > 0) ? 5'b10111 : 5'b10101);
      step();
    end
    idleIns();
    for (int i = 0; i < 8; i++) begin
      rd_addr1 = 4'(i);
      rd_addr2 = 4'(i + 8);
      pushExp("after_sweep", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b11111);
      step();
    end

    // Reset in the middle of a sweep.
    wr(2'b10, 4'd3, 16'h3333, 4'd14, 16'hEEEE, 1'b0);
    step();
    idleIns();
    clr_req = 1'b1;
    step();
    idleIns();
    repeat (6) step();
    rst      = 1'b1;
    rd_addr1 = 4'd14;
    rd_addr2 = 4'd3;
    pushExp("reset_mid_sweep", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b10011);
    step();
    rst = 1'b0;
    wr(2'b10, 4'd14, 16'h1414, 4'd1, 16'h0101, 1'b0);
    pushExp("idle_after_reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b10000);
    step();
    idleIns();
    rd_addr1 = 4'd14;
    rd_addr2 = 4'd1;
    pushExp("write_after_reset", 16'h1414, 16'h0101, 1'b0, 1'b0, 1'b0, 5'b11111);
    step();

    repeat (3) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
